audio_cmd_master: RTL and testbench
===================================

# audio_cmd_master

Wishbone initiator that turns game-logic sound events into register writes on the audio peripheral's Wishbone slave port. Events are queued in a small FIFO and each is issued as a single write of the event code to the peripheral's sound-select register at byte offset 0x00. The block sits between the game-logic event sources and the audio peripheral's Wishbone slave port, so sound requests no longer need the RISC-V core. A handshake timeout and an optional read-back check report a stuck or misbehaving slave.

## Interface
Parameters:
- FIFO_DEPTH, 4, event queue depth; power of two, ≥2.
- TIMEOUT, 255, maximum number of cycles to wait for `wb_ack_i` per bus cycle; 1..1023.
- SEL_ADR, 8'h00, byte address of the sound-select register.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset; active-low, synchronous.
- evt_valid_i  in  1  event request.
- evt_code_i  in  4  sound code; 0 = stop audio.
- evt_ready_o  out  1  FIFO not full; an event is accepted when `evt_valid_i && evt_ready_o`.
- wb_cyc_o, wb_stb_o  out  1  bus cycle / strobe; always driven equal.
- wb_we_o  out  1  1 = write, 0 = read.
- wb_adr_o  out  8  always `SEL_ADR`.
- wb_dat_o  out  32  `{28'h0, code}`.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.
- busy_o  out  1  FSM not in IDLE, or FIFO not empty.
- err_o  out  1  sticky error flag.
- err_clr_i  in  1  clears `err_o`.

## Operation
- FIFO:
  - Push on accept.
  - Pop when IDLE moves to WRITE; the popped code is latched in `cmd_q`.
  - When full, `evt_ready_o` is 0 and `evt_valid_i` is ignored.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits plus one wrap bit.
- FSM states:
  - IDLE: if the FIFO is not empty, go to WRITE.
  - WRITE: `cyc/stb/we` = 1, `dat` = `cmd_q`.
    - On `wb_ack_i`: go to VERIFY when the macro is defined, otherwise GAP.
    - On timeout: go to GAP and set `err_o`.
  - VERIFY (macro only): `cyc/stb` = 1, `we` = 0.
    - On `wb_ack_i`: compare `wb_dat_i[3:0]` with `cmd_q` and check that `wb_dat_i[31:4]` is 0. On mismatch, set `err_o`. Go to GAP.
    - On timeout: set `err_o` and go to GAP.
  - GAP: bus idle for one cycle so the slave's ack flop can clear, then go to IDLE.
- Timeout counter:
  - Cleared on entry to WRITE or VERIFY; increments every cycle while waiting for ack.
  - Timeout fires when the count reaches TIMEOUT with no ack. A command that times out is dropped, not retried.
- `err_o`:
  - Set has priority over `err_clr_i` in the same cycle.
  - Cleared only by `err_clr_i` or by reset.
- Reset:
  - FIFO emptied, FSM to IDLE, counters and `cmd_q` cleared.
  - Any in-flight bus cycle is abandoned: `cyc/stb` are 0 in the cycle after reset is sampled.

## Timing
- Reset values:
  - 1: `evt_ready_o`.
  - 0: `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_dat_o`, `busy_o`, `err_o`.
  - `SEL_ADR`: `wb_adr_o`.
- Event latency: event accepted at edge N with the FSM idle → FIFO non-empty after N → `cyc/stb` high from edge N+1.
- Bus cycle handshake:
  - `cyc/stb` go low on the edge that samples `wb_ack_i` = 1.
  - `wb_dat_o` and `wb_we_o` stay stable for the whole cycle.
- Against the audio peripheral (ack one cycle after `stb`), one write takes 4 cycles (WRITE, WRITE+ack, GAP, IDLE), so the sustained rate is one command per 4 cycles. With the macro defined it is one per 6 cycles.
- Back-to-back FIFO entries always have at least one GAP cycle between them.

## Configuration
- `AUDIO_CMD_READBACK_EN`:
  - Defined: the VERIFY state is compiled in, and each write is followed by a read of `SEL_ADR` with the mismatch check above.
  - Undefined: WRITE goes straight to GAP and `wb_we_o` is constant 1 whenever `wb_cyc_o` is high.

## Test plan
- Reset then idle: hold `wb_rst_i` = 0 for 3 cycles, release → `evt_ready_o` = 1, `cyc` = 0, `err_o` = 0, `busy_o` = 0.
- Single event, slave acks 1 cycle after `stb`: code 1 → one write with `adr` = 0x00 and `dat` = 0x00000001; `stb` high for exactly 2 cycles; `busy_o` falls 2 cycles after `stb` drops; `err_o` = 0.
- Burst and full FIFO: push codes 1, 2, 0, 1, 2 with no wait while `ack` is held off → `evt_ready_o` = 0 after 4 pushes are queued beyond the in-flight one. After release, writes occur in order 1, 2, 0, 1, 2 and nothing is lost.
- Timeout: `ack` never asserted, event code 3 → `stb` drops after TIMEOUT cycles and `err_o` = 1. The next event is still issued. Pulsing `err_clr_i` gives `err_o` = 0.
- Reset mid-cycle: assert reset while `stb` = 1 → `cyc/stb` = 0 the next cycle and the FIFO is empty. No write occurs after reset is released.
- Read-back (macro defined): the slave returns 0x00000005 for written code 2 → `err_o` = 1. The slave returns 0x00000002 → `err_o` stays 0.

Source files
------------

// File: rtl/audio_cmd_master.sv
// -----------------------------------------------------------------------------
// audio_cmd_master
//
// Wishbone initiator that forwards game-logic sound events to the audio
// peripheral. Each accepted event code is queued in a small FIFO and later
// issued as a single Wishbone write of {28'h0, code} to SEL_ADR. A per-cycle
// ack timeout and an optional read-back check flag a stuck or misbehaving
// slave through the sticky err_o.
//
// Optional feature macro: AUDIO_CMD_READBACK_EN
//   defined   : every write is followed by a read of SEL_ADR; the returned
//               word must equal {28'h0, code}, otherwise err_o is set.
//   undefined : WRITE goes straight to GAP; wb_we_o is 1 whenever wb_cyc_o is.
//
// Handshakes:
//   Event side is valid/ready: an event is transferred on a rising edge where
//   evt_valid_i && evt_ready_o; evt_code_i must be valid while evt_valid_i is
//   high, and when evt_ready_o is low the request is ignored (not held off).
//   Bus side is classic Wishbone: cyc/stb stay high until the edge that
//   samples wb_ack_i = 1; we/adr/dat are stable for the whole bus cycle.
//
// Ports:
//   wb_clk_i     clock, all logic on the rising edge
//   wb_rst_i     synchronous reset, active low
//   evt_valid_i  event request
//   evt_code_i   4-bit sound code (0 = stop audio)
//   evt_ready_o  FIFO not full
//   wb_cyc_o     bus cycle
//   wb_stb_o     strobe (always equal to wb_cyc_o)
//   wb_we_o      1 = write, 0 = read
//   wb_adr_o     constant SEL_ADR
//   wb_dat_o     {28'h0, current command}
//   wb_dat_i     read data from the slave
//   wb_ack_i     slave acknowledge
//   busy_o       registered: engine not idle or FIFO not empty
//   err_o        sticky error flag
//   err_clr_i    clears err_o (a same-cycle set wins)
//   dbg_state    current FSM state, for debug/checkers
// -----------------------------------------------------------------------------
module audio_cmd_master #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] SEL_ADR    = 8'h00
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        evt_valid_i,
  input  logic [3:0]  evt_code_i,
  output logic        evt_ready_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [9:0]  TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [3:0]  cmd_q;
  logic [9:0]  tmo_cnt;
  logic        cyc_q;
  logic        we_q;
  logic        busy_q;
  logic        err_q;

  logic fifo_empty;
  logic fifo_full;
  logic push;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = evt_valid_i && !fifo_full;

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= evt_code_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cmd_q   <= '0;
      tmo_cnt <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // busy is registered from the current state, so it trails the FSM by
      // one cycle.
      busy_q <= (state != S_IDLE) || !fifo_empty;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      // Clear first; any error set below overrides it in the same cycle.
      if (err_clr_i) begin
        err_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cmd_q   <= mem[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + PTR_ONE;
            tmo_cnt <= '0;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            state   <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (wb_ack_i) begin
`ifdef AUDIO_CMD_READBACK_EN
            // Keep cyc/stb asserted and turn the cycle into a read.
            we_q    <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_VERIFY;
`else
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            state   <= S_GAP;
`endif
          end else if (tmo_cnt == TMO_LAST) begin
            // Timed-out command is dropped, not retried.
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b1;
            state <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end

`ifdef AUDIO_CMD_READBACK_EN
        S_VERIFY: begin
          if (wb_ack_i) begin
            if (wb_dat_i != {28'h0, cmd_q}) begin
              err_q <= 1'b1;
            end
            cyc_q <= 1'b0;
            state <= S_GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            cyc_q <= 1'b0;
            err_q <= 1'b1;
            state <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
`endif

        // One idle bus cycle lets the slave's ack flop drop before the next
        // command starts.
        S_GAP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef AUDIO_CMD_READBACK_EN
  // Read data is only consumed by the read-back check.
  logic unused_rdata;
  assign unused_rdata = &{1'b0, wb_dat_i};
`endif

  assign evt_ready_o = !fifo_full;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = SEL_ADR;
  assign wb_dat_o    = {28'h0, cmd_q};
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_audio_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_audio_cmd_master
//
// Bench for audio_cmd_master: a table of single-command vectors, hand-written
// sequences for burst/full FIFO, timeout, error-clear priority, reset in the
// middle of a bus cycle and (when AUDIO_CMD_READBACK_EN is defined) read-back,
// followed by a randomized run checked against a queue-and-timer model.
// A registered Wishbone slave acks one cycle after it sees stb.
// -----------------------------------------------------------------------------
module tb_audio_cmd_master;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 12;
  localparam int LIMIT      = 500;
`ifdef AUDIO_CMD_READBACK_EN
  localparam int NORM_HI = 4;   // stb samples high: write + read
  localparam int PERIOD  = 6;   // edges between successive FIFO pops
`else
  localparam int NORM_HI = 2;
  localparam int PERIOD  = 4;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        wb_rst_i;
  logic        evt_valid_i;
  logic [3:0]  evt_code_i;
  logic        evt_ready_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i;
  logic [1:0]  dbg_state;

  audio_cmd_master #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT),
    .SEL_ADR   (8'h00)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .evt_valid_i(evt_valid_i),
    .evt_code_i (evt_code_i),
    .evt_ready_o(evt_ready_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .err_clr_i  (err_clr_i),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  // slave controls
  bit          ack_en    = 1'b1;
  bit          rd_ovr_en = 1'b0;
  logic [31:0] rd_ovr    = '0;
  logic [31:0] slave_reg = '0;

  typedef struct {
    logic [3:0] code;
    bit         ack_on;
    int         exp_hi;
    bit         exp_err;
  } vec_t;
  vec_t vecs[7];

  // model state for the random run
  logic [3:0] mq[$];
  int         m_timer;
  bit         m_ready;
  bit         r_v;
  logic [3:0] r_code;
  int         lat, hi, lag, cnt, t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound of %0d cycles expired", name, LIMIT);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] code);
    evt_valid_i = 1'b1;
    evt_code_i  = code;
    tick();
    evt_valid_i = 1'b0;
  endtask

  // Called right after the accept edge: measures accept->stb latency, stb
  // high samples and cycles from stb drop until busy_o falls.
  task automatic wait_cmd(output int o_lat, output int o_hi, output int o_lag);
    int tt;
    o_lat = 0; o_hi = 0; o_lag = 0; tt = 0;
    while (!wb_stb_o && tt < LIMIT) begin tick(); o_lat++; tt++; end
    while (wb_stb_o && tt < LIMIT) begin o_hi++; tick(); tt++; end
    while (busy_o && tt < LIMIT) begin o_lag++; tick(); tt++; end
    if (tt >= LIMIT) bound_fail("wait_cmd");
  endtask

  task automatic wait_idle();
    int tt;
    tt = 0;
    while (busy_o && tt < LIMIT) begin tick(); tt++; end
    if (tt >= LIMIT) bound_fail("wait_idle");
  endtask

  // ---------------- Wishbone slave ----------------
  initial begin : slave
    logic s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_dat;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      s_cyc = wb_cyc_o; s_stb = wb_stb_o; s_we = wb_we_o;
      s_dat = wb_dat_o; s_ack = wb_ack_i;
      @(posedge clk);
      #1;
      if (s_ack && s_we && s_cyc) slave_reg = s_dat;
      wb_ack_i = ack_en && s_cyc && s_stb && !s_ack;
      wb_dat_i = rd_ovr_en ? rd_ovr : slave_reg;
    end
  end

  // ---------------- bus monitor / scoreboard ----------------
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (wb_cyc_o || wb_stb_o) check("cyc_eq_stb", {31'h0, wb_stb_o}, {31'h0, wb_cyc_o});
      if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) begin
        check("write_adr", {24'h0, wb_adr_o}, 32'h0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got 0x%0h, expected no write", wb_dat_o);
        end else begin
          e = exp_q.pop_front();
          check("write_data", wb_dat_o, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    vecs[0] = '{4'd1,  1'b1, NORM_HI, 1'b0};
    vecs[1] = '{4'd2,  1'b1, NORM_HI, 1'b0};
    vecs[2] = '{4'd0,  1'b1, NORM_HI, 1'b0};
    vecs[3] = '{4'd15, 1'b1, NORM_HI, 1'b0};
    vecs[4] = '{4'd3,  1'b0, TIMEOUT, 1'b1};
    vecs[5] = '{4'd7,  1'b1, NORM_HI, 1'b1};   // next event still issued, err sticky
    vecs[6] = '{4'd10, 1'b1, NORM_HI, 1'b1};

    wb_rst_i    = 1'b0;
    evt_valid_i = 1'b0;
    evt_code_i  = '0;
    err_clr_i   = 1'b0;

    // reset then idle
    repeat (3) tick();
    check("rst_ready", {31'h0, evt_ready_o}, 32'h1);
    check("rst_cyc",   {31'h0, wb_cyc_o},    32'h0);
    check("rst_stb",   {31'h0, wb_stb_o},    32'h0);
    check("rst_we",    {31'h0, wb_we_o},     32'h0);
    check("rst_dat",   wb_dat_o,             32'h0);
    check("rst_adr",   {24'h0, wb_adr_o},    32'h0);
    check("rst_busy",  {31'h0, busy_o},      32'h0);
    check("rst_err",   {31'h0, err_o},       32'h0);
    wb_rst_i = 1'b1;
    tick();
    check("idle_ready", {31'h0, evt_ready_o}, 32'h1);
    check("idle_cyc",   {31'h0, wb_cyc_o},    32'h0);
    check("idle_busy",  {31'h0, busy_o},      32'h0);
    check("idle_err",   {31'h0, err_o},       32'h0);

    // table-driven single commands
    for (int i = 0; i < 7; i++) begin
      ack_en = vecs[i].ack_on;
      if (vecs[i].ack_on) exp_q.push_back({28'h0, vecs[i].code});
      push(vecs[i].code);
      check("cyc_not_yet", {31'h0, wb_cyc_o}, 32'h0);
      wait_cmd(lat, hi, lag);
      check("lat",      lat, 32'd1);
      check("stb_hi",   hi, vecs[i].exp_hi);
      check("busy_lag", lag, 32'd2);
      check("err",      {31'h0, err_o}, {31'h0, vecs[i].exp_err});
      check("dat_hold", wb_dat_o, {28'h0, vecs[i].code});
    end
    ack_en = 1'b1;

    // err clear
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("err_clr", {31'h0, err_o}, 32'h0);

    // set beats clear: clear held high across a timeout
    ack_en    = 1'b0;
    err_clr_i = 1'b1;
    push(4'd6);
    t = 0;
    while (!wb_stb_o && t < LIMIT) begin tick(); t++; end
    while (wb_stb_o && t < LIMIT) begin tick(); t++; end
    if (t >= LIMIT) bound_fail("prio_wait");
    check("err_set_prio", {31'h0, err_o}, 32'h1);
    tick();
    check("err_clr_after", {31'h0, err_o}, 32'h0);
    err_clr_i = 1'b0;
    ack_en    = 1'b1;
    wait_idle();

    // burst into a stalled slave until full
    ack_en = 1'b0;
    exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    push(4'd1); check("burst_rdy1", {31'h0, evt_ready_o}, 32'h1);
    push(4'd2); check("burst_rdy2", {31'h0, evt_ready_o}, 32'h1);
    push(4'd0); check("burst_rdy3", {31'h0, evt_ready_o}, 32'h1);
    push(4'd1); check("burst_rdy4", {31'h0, evt_ready_o}, 32'h1);
    push(4'd2); check("burst_full", {31'h0, evt_ready_o}, 32'h0);
    push(4'd9); check("burst_ignored", {31'h0, evt_ready_o}, 32'h0);
    ack_en = 1'b1;
    wait_idle();
    check("burst_drained", exp_q.size(), 32'd0);
    check("burst_err",     {31'h0, err_o}, 32'h0);
    check("burst_ready",   {31'h0, evt_ready_o}, 32'h1);

`ifdef AUDIO_CMD_READBACK_EN
    // read-back mismatch and match
    rd_ovr_en = 1'b1;
    rd_ovr    = 32'h0000_0005;
    exp_q.push_back(32'd2);
    push(4'd2);
    wait_cmd(lat, hi, lag);
    check("rb_mismatch_err", {31'h0, err_o}, 32'h1);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    rd_ovr    = 32'h0000_0012;   // low nibble right, upper bits wrong
    exp_q.push_back(32'd2);
    push(4'd2);
    wait_cmd(lat, hi, lag);
    check("rb_upper_err", {31'h0, err_o}, 32'h1);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    rd_ovr_en = 1'b0;
    exp_q.push_back(32'd2);
    push(4'd2);
    wait_cmd(lat, hi, lag);
    check("rb_match_err", {31'h0, err_o}, 32'h0);
`endif

    // reset in the middle of a bus cycle
    ack_en = 1'b0;
    push(4'd4);
    push(4'd5);
    check("mid_stb", {31'h0, wb_stb_o}, 32'h1);
    wb_rst_i = 1'b0;
    tick();
    check("mid_rst_cyc",   {31'h0, wb_cyc_o},    32'h0);
    check("mid_rst_stb",   {31'h0, wb_stb_o},    32'h0);
    check("mid_rst_ready", {31'h0, evt_ready_o}, 32'h1);
    check("mid_rst_busy",  {31'h0, busy_o},      32'h0);
    wb_rst_i = 1'b1;
    ack_en   = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wb_stb_o) cnt++;
    end
    check("mid_no_write", cnt, 32'd0);
    check("mid_busy",     {31'h0, busy_o}, 32'h0);

    // randomized run against a queue + issue-timer model
    wb_rst_i = 1'b0;
    tick();
    wb_rst_i = 1'b1;
    tick();
    mq.delete();
    m_timer = 0;
    for (int c = 0; c < 400; c++) begin
      r_v    = (c < 360) ? ($urandom_range(0, 2) != 0) : 1'b0;
      r_code = 4'($urandom_range(0, 15));
      evt_valid_i = r_v;
      evt_code_i  = r_code;
      m_ready = (mq.size() < FIFO_DEPTH);
      check("rand_ready", {31'h0, evt_ready_o}, {31'h0, m_ready});
      tick();
      if (m_timer == 0 && mq.size() > 0) begin
        exp_q.push_back({28'h0, mq.pop_front()});
        m_timer = PERIOD - 1;
      end else if (m_timer > 0) begin
        m_timer--;
      end
      if (r_v && m_ready) mq.push_back(r_code);
    end
    evt_valid_i = 1'b0;
    wait_idle();
    check("rand_model_empty", mq.size(), 32'd0);
    check("rand_drained",     exp_q.size(), 32'd0);
    check("rand_err",         {31'h0, err_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
